spi_master_fifo: RTL and testbench
==================================

Name: spi_master_fifo

Overview:
Parametrised memory-mapped SPI master for the system bus; successor to the single-byte, fixed-rate, mode-0, single-CS SPI logic in the current top level.
- Adds programmable SCK divider, CPOL/CPHA, NCS chip selects, CS modes, and TX/RX byte FIFOs.
- Sits beside the BRAM on the core's request/response port. Same register map as the existing software driver: txdata 0x48, rxdata 0x4c, csmode 0x18.

Parameters:
TX_LG, 3, log2 TX FIFO depth (depth 8)
RX_LG, 3, log2 RX FIFO depth (depth 8)
NCS, 4, number of chip-select outputs (1..8)
DIV_W, 12, width of SCK divider register

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
rq_en  input  1  request valid, one cycle per request, always accepted
rq_addr  input  7  register byte offset, word-aligned
rq_iswrite  input  1  1 = write, 0 = read
rq_data  input  32  write data
rs_en  output  1  response valid, exactly 1 cycle after every rq_en
rs_data  output  32  read data; 0 for writes and unmapped offsets
spi_clk  output  1  SCK
spi_mosi  output  1  serial data out, MSB first
spi_miso  input  1  serial data in
spi_csn  output  NCS  active-low chip selects

Behaviour:
Reset values:
- rs_en=0, rs_data=0, spi_clk=CPOL (0), spi_mosi=0, spi_csn=all 1.
- FIFOs empty; sckdiv=3, sckmode=0, csid=0, csdef=all 1, csmode=0.
Registers (R/W unless noted):
- 0x00 sckdiv[DIV_W-1:0]: SCK half-period = sckdiv+1 clk cycles.
- 0x04 sckmode[1:0]: bit0 CPHA, bit1 CPOL.
- 0x10 csid: index of asserted CS. Values >= NCS are ignored on write.
- 0x14 csdef[NCS-1:0]: inactive level per CS.
- 0x18 csmode[1:0]: 0 AUTO, 2 HOLD, 3 OFF; 1 behaves as AUTO.
- 0x48 txdata:
  - Read returns {full,31'b0}.
  - Write pushes rq_data[7:0] if not full; dropped silently if full.
- 0x4c rxdata:
  - Read returns {empty,23'b0,byte}, with byte=0 when empty.
  - Pop happens only when not empty.
Bus timing:
- Register writes take effect the cycle after rq_en.
- Reads sample state in the rq_en cycle; rs_data/rs_en are registered.
- Same-cycle TX push by the bus and pop by the engine are both honoured; same for RX.
Engine FSM:
- IDLE -> when TX not empty and csmode!=OFF: pop byte, assert CS (csn[csid] = !csdef[csid]), go to SETUP.
- IDLE -> when TX not empty and csmode==OFF: pop and shift without asserting CS.
- SETUP: wait one half-period, then go to SHIFT.
- SHIFT: 16 half-periods; SCK toggles at the end of each half-period.
  - Sample edge is the leading edge when CPHA=0, the trailing edge when CPHA=1.
  - MOSI changes on the opposite edge.
  - CPHA=0: bit7 is driven on SETUP entry.
- After the 8th sample: if RX is not full, push the byte; otherwise discard it. Then go to GAP.
- GAP (one half-period):
  - TX not empty -> next byte, straight into SHIFT; CS stays asserted in all modes.
  - TX empty and csmode=AUTO -> deassert CS, go to IDLE.
  - TX empty and csmode=HOLD -> keep CS, go to IDLE.
CS rules:
- A csmode write leaving HOLD while IDLE deasserts CS the next cycle.
- csid/csdef changes while busy apply from the next IDLE->SETUP.
- sckdiv/sckmode changes while busy take effect at the next byte boundary, latched on SETUP/GAP entry.
- Reset mid-frame: outputs return to reset values immediately (async); no partial byte is pushed.

Optional Feature:
SPI_IRQ_EN
- Defined:
  - Adds output irq (1 bit).
  - Adds register 0x70 ie[1:0]: bit0 txwm, bit1 rxwm.
  - Adds register 0x74 ip[1:0], read-only.
  - Adds register 0x50 txmark and register 0x54 rxmark, each TX_LG+1/RX_LG+1 bits.
  - txwm = tx_count < txmark; rxwm = rx_count > rxmark.
  - irq = |(ie & ip), registered, reset 0.
- Undefined: none of these ports or registers exist; offsets 0x50/0x54/0x70/0x74 read 0 and ignore writes.

Test Plan:
- Reset: write sckdiv=0, sckmode=0, txdata=0xA5 -> csn[0] low, 8 SCK pulses of period 2 clk, MOSI 10100101; after GAP csn all 1; with MISO tied to MOSI, rxdata read = 0x000000A5, then second read = 0x80000000.
- Write txdata 9 times back-to-back with sckdiv=100 -> txdata read shows bit31=1 after 8 pushes (1 may have popped); 9th write dropped only if full; total bytes on wire = number accepted.
- Mode 3 (sckmode=3), sckdiv=2, byte 0x3C -> SCK idles high, half-period 3 clk, MISO sampled on rising edges, rx = 0x3C via loopback.
- csmode=HOLD, csid=2, two bytes sent -> csn[2] low across both bytes and after; write csmode=0 -> csn[2] high next cycle; csn[0,1,3] stay high throughout.
- Send 9 bytes without reading RX (depth 8) -> 8 bytes stored, 9th discarded, 9th rxdata read returns 0x80000000.
- Assert resetn low during bit 4 of a frame -> spi_csn=all 1, spi_clk=0, rxdata read after release = 0x80000000; with SPI_IRQ_EN, ie=1, txmark=1 -> irq=1 once TX drains.

Source files
------------

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: bus-mapped SPI master with SCK divider, CPOL/CPHA, chip-select modes and TX/RX byte FIFOs.
// Define SPI_IRQ_EN to add the irq output and the watermark registers at 0x50/0x54/0x70/0x74.
module spi_master_fifo #(
   parameter int TX_LG = 3,
   parameter int RX_LG = 3,
   parameter int NCS = 4,
   parameter int DIV_W = 12
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           rq_en,
   input  logic [6:0]     rq_addr,
   input  logic           rq_iswrite,
   input  logic [31:0]    rq_data,
   output logic           rs_en,
   output logic [31:0]    rs_data,
   output logic           spi_clk,
   output logic           spi_mosi,
   input  logic           spi_miso,
   output logic [NCS-1:0] spi_csn
`ifdef SPI_IRQ_EN
   ,
   output logic           irq
`endif
);
   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
   localparam logic [1:0] CS_HOLD = 2'd2;
   localparam logic [1:0] CS_OFF = 2'd3;

   state_t state, state_nx;
   logic [DIV_W-1:0] sckdiv, div_l, div_cnt;
   logic [1:0] sckmode, csmode, csmode_nx;
   logic [2:0] csid;
   logic [NCS-1:0] csdef;
   logic cpha_l, cs_on;
   logic [3:0] hc;
   logic [7:0] tx_sr, rx_sr, tx_byte, rx_byte;
   logic [7:0] tx_mem [2**TX_LG];
   logic [7:0] rx_mem [2**RX_LG];
   logic [TX_LG:0] tx_wp, tx_rp, tx_cnt;
   logic [RX_LG:0] rx_wp, rx_rp, rx_cnt;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic wr, rd, tx_push, rx_pop, tx_pop, rx_push;
   logic half_end, last_half, latch_cfg, cpha_use, edge_sample, edge_shift;
   logic [31:0] rd_data;

   assign wr = rq_en & rq_iswrite;
   assign rd = rq_en & ~rq_iswrite;
   assign tx_cnt = tx_wp - tx_rp;
   assign rx_cnt = rx_wp - rx_rp;
   assign tx_full = tx_cnt[TX_LG];
   assign rx_full = rx_cnt[RX_LG];
   assign tx_empty = tx_cnt == '0;
   assign rx_empty = rx_cnt == '0;
   assign tx_push = wr && rq_addr == 7'h48 && !tx_full;
   assign rx_pop = rd && rq_addr == 7'h4c && !rx_empty;
   assign csmode_nx = (wr && rq_addr == 7'h18) ? rq_data[1:0] : csmode;
   assign tx_byte = tx_mem[tx_rp[TX_LG-1:0]];
   assign half_end = div_cnt == div_l;
   assign last_half = state == SHIFT && half_end && hc == 4'd15;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!tx_empty) state_nx = SETUP;
         SETUP:   if (half_end) state_nx = SHIFT;
         SHIFT:   if (last_half) state_nx = GAP;
         GAP:     if (half_end) state_nx = tx_empty ? IDLE : SHIFT;
         default: state_nx = IDLE;
      endcase
   end

   // Even half-periods end on the leading SCK edge; CPHA picks which parity samples.
   always_comb begin
      tx_pop = (state == IDLE || (state == GAP && half_end)) && !tx_empty;
      latch_cfg = (state == IDLE && !tx_empty) || last_half;
      rx_push = last_half && !rx_full;
      cpha_use = state == IDLE ? sckmode[0] : cpha_l;
      edge_sample = state == SHIFT && half_end && hc[0] == cpha_l;
      edge_shift = state == SHIFT && half_end && hc[0] != cpha_l;
      rx_byte = cpha_l ? {rx_sr[6:0], spi_miso} : rx_sr;
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         div_l <= '0;
         cpha_l <= 1'b0;
         div_cnt <= '0;
         hc <= '0;
         tx_sr <= '0;
         rx_sr <= '0;
         spi_clk <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         div_cnt <= (state == IDLE || half_end) ? '0 : div_cnt + DIV_W'(1);
         if (latch_cfg) begin
            div_l <= sckdiv;
            cpha_l <= sckmode[0];
         end
         if (state == IDLE || latch_cfg) spi_clk <= sckmode[1];
         else if (state == SHIFT && half_end) spi_clk <= ~spi_clk;
         if (tx_pop) hc <= '0;
         else if (state == SHIFT && half_end) hc <= hc + 4'd1;
         if (tx_pop) begin
            tx_sr <= cpha_use ? tx_byte : {tx_byte[6:0], 1'b0};
            if (!cpha_use) spi_mosi <= tx_byte[7];
         end else if (edge_shift) begin
            spi_mosi <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
         end
         if (edge_sample) rx_sr <= {rx_sr[6:0], spi_miso};
      end

   // Chip select: asserted at frame start, released by AUTO at the end or by leaving HOLD while idle.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cs_on <= 1'b0;
         spi_csn <= '1;
      end else if (state == IDLE && !tx_empty) begin
         cs_on <= csmode != CS_OFF;
         spi_csn <= csmode != CS_OFF ? csdef ^ (NCS'(1) << csid) : csdef;
      end else if (state == IDLE) begin
         if (!cs_on || csmode_nx != CS_HOLD) begin
            cs_on <= 1'b0;
            spi_csn <= csdef;
         end
      end else if (state == GAP && half_end && tx_empty && !csmode[1]) begin
         cs_on <= 1'b0;
         spi_csn <= csdef;
      end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TX_LG-1:0]] <= rq_data[7:0];
      if (rx_push) rx_mem[rx_wp[RX_LG-1:0]] <= rx_byte;
   end

`ifdef SPI_IRQ_EN
   logic [1:0] ie, ip;
   logic [TX_LG:0] txmark;
   logic [RX_LG:0] rxmark;
   assign ip = {rx_cnt > rxmark, tx_cnt < txmark};
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         ie <= '0;
         txmark <= '0;
         rxmark <= '0;
         irq <= 1'b0;
      end else begin
         if (wr && rq_addr == 7'h70) ie <= rq_data[1:0];
         if (wr && rq_addr == 7'h50) txmark <= rq_data[TX_LG:0];
         if (wr && rq_addr == 7'h54) rxmark <= rq_data[RX_LG:0];
         irq <= |(ie & ip);
      end
`endif

   always_comb begin
      rd_data = '0;
      case (rq_addr)
         7'h00:   rd_data = 32'(sckdiv);
         7'h04:   rd_data = {30'd0, sckmode};
         7'h10:   rd_data = {29'd0, csid};
         7'h14:   rd_data = 32'(csdef);
         7'h18:   rd_data = {30'd0, csmode};
         7'h48:   rd_data = {tx_full, 31'd0};
         7'h4c:   rd_data = {rx_empty, 23'd0, rx_empty ? 8'd0 : rx_mem[rx_rp[RX_LG-1:0]]};
`ifdef SPI_IRQ_EN
         7'h50:   rd_data = 32'(txmark);
         7'h54:   rd_data = 32'(rxmark);
         7'h70:   rd_data = {30'd0, ie};
         7'h74:   rd_data = {30'd0, ip};
`endif
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         sckdiv <= DIV_W'(3);
         sckmode <= '0;
         csid <= '0;
         csdef <= '1;
         csmode <= '0;
         rs_en <= 1'b0;
         rs_data <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + (TX_LG+1)'(1);
         if (tx_pop) tx_rp <= tx_rp + (TX_LG+1)'(1);
         if (rx_push) rx_wp <= rx_wp + (RX_LG+1)'(1);
         if (rx_pop) rx_rp <= rx_rp + (RX_LG+1)'(1);
         if (wr && rq_addr == 7'h00) sckdiv <= rq_data[DIV_W-1:0];
         if (wr && rq_addr == 7'h04) sckmode <= rq_data[1:0];
         if (wr && rq_addr == 7'h10 && rq_data < 32'(NCS)) csid <= rq_data[2:0];
         if (wr && rq_addr == 7'h14) csdef <= rq_data[NCS-1:0];
         csmode <= csmode_nx;
         rs_en <= rq_en;
         rs_data <= rd ? rd_data : '0;
      end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: register vector table plus MOSI/RX scoreboards for spi_master_fifo with MISO looped to MOSI.
`timescale 1ns/1ps
module tb_spi_master_fifo;
   localparam int NCS = 4;
   logic clk = 1'b0;
   logic resetn = 1'b1;
   logic rq_en = 1'b0;
   logic rq_iswrite = 1'b0;
   logic [6:0] rq_addr = '0;
   logic [31:0] rq_data = '0;
   logic rs_en, spi_clk, spi_mosi, spi_miso;
   logic [31:0] rs_data;
   logic [NCS-1:0] spi_csn;
`ifdef SPI_IRQ_EN
   logic irq;
`endif

   assign spi_miso = spi_mosi;
   always #5 clk = ~clk;

   spi_master_fifo #(.TX_LG(3), .RX_LG(3), .NCS(NCS), .DIV_W(12)) dut (
      .clk(clk), .resetn(resetn), .rq_en(rq_en), .rq_addr(rq_addr), .rq_iswrite(rq_iswrite),
      .rq_data(rq_data), .rs_en(rs_en), .rs_data(rs_data), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_csn(spi_csn)
`ifdef SPI_IRQ_EN
      , .irq(irq)
`endif
   );

   typedef struct {
      logic [6:0]  addr;
      logic        w;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   int checks = 0, errors = 0;
   logic [7:0] exp_mosi[$];
   logic [7:0] exp_rx[$];
   int rx_model = 0;
   int mon_bits = 0, mon_bytes = 0, ncyc = 0, last_rise = 0, exp_period = 2;
   logic [7:0] mon_sr = '0;
   logic prev_sck = 1'b0;
   logic per_bad = 1'b0;
   logic [NCS-1:0] exp_csn = '1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // SPI monitor: captures MOSI on rising SCK while a chip select is low (modes 0 and 3 used here).
   always @(negedge clk) begin
      ncyc++;
      if (&spi_csn) begin
         mon_bits = 0;
         per_bad = 1'b0;
      end else if (spi_clk && !prev_sck) begin
         if (mon_bits != 0 && ncyc - last_rise != exp_period) per_bad = 1'b1;
         last_rise = ncyc;
         mon_sr = {mon_sr[6:0], spi_mosi};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            mon_bytes++;
            chk("sck_period_ok", {31'd0, per_bad}, 32'd0);
            per_bad = 1'b0;
            chk("csn_during_byte", 32'(spi_csn), 32'(exp_csn));
            if (exp_mosi.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL mosi_byte: got unexpected byte %h, expected none", mon_sr);
            end else chk("mosi_byte", {24'd0, mon_sr}, {24'd0, exp_mosi.pop_front()});
         end
      end
      prev_sck = spi_clk;
   end

   task automatic bus(input logic [6:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] r, output logic v);
      rq_en = 1'b1;
      rq_addr = a;
      rq_iswrite = w;
      rq_data = d;
      @(negedge clk);
      r = rs_data;
      v = rs_en;
      rq_en = 1'b0;
      rq_iswrite = 1'b0;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      logic [31:0] r;
      logic v;
      bus(a, 1'b1, d, r, v);
   endtask

   task automatic rd_chk(input string name, input logic [6:0] a, input logic [31:0] e);
      logic [31:0] r;
      logic v;
      bus(a, 1'b0, 32'd0, r, v);
      chk(name, r, e);
   endtask

   task automatic send(input logic [7:0] b);
      exp_mosi.push_back(b);
      if (rx_model < 8) begin
         exp_rx.push_back(b);
         rx_model++;
      end
      wr(7'h48, {24'd0, b});
   endtask

   task automatic read_rx(input string name);
      logic [31:0] e;
      e = 32'h8000_0000;
      if (exp_rx.size() > 0) begin
         e = {24'd0, exp_rx.pop_front()};
         rx_model--;
      end
      rd_chk(name, 7'h4c, e);
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int c = 0;
      while (mon_bytes < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("bytes_on_wire", 32'(mon_bytes), 32'(n));
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      exp_mosi.delete();
      exp_rx.delete();
      rx_model = 0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      mon_bytes = 0;
      @(negedge clk);
   endtask

   task automatic add(input logic [6:0] a, input logic w, input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.addr = a;
      v.w = w;
      v.d = d;
      v.exp = e;
      vecs.push_back(v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      logic v;
      int c;
      #1;
      do_reset();
      chk("reset_rs_en", {31'd0, rs_en}, 32'd0);
      chk("reset_rs_data", rs_data, 32'd0);
      chk("reset_spi_clk", {31'd0, spi_clk}, 32'd0);
      chk("reset_spi_mosi", {31'd0, spi_mosi}, 32'd0);
      chk("reset_spi_csn", 32'(spi_csn), 32'hF);

      add(7'h00, 0, 0, 32'd3);
      add(7'h04, 0, 0, 32'd0);
      add(7'h10, 0, 0, 32'd0);
      add(7'h14, 0, 0, 32'hF);
      add(7'h18, 0, 0, 32'd0);
      add(7'h48, 0, 0, 32'd0);
      add(7'h4c, 0, 0, 32'h8000_0000);
      add(7'h00, 1, 32'hFFFFF, 32'd0);
      add(7'h00, 0, 0, 32'hFFF);
      add(7'h04, 1, 32'd7, 32'd0);
      add(7'h04, 0, 0, 32'd3);
      add(7'h10, 1, 32'd5, 32'd0);
      add(7'h10, 0, 0, 32'd0);
      add(7'h10, 1, 32'd3, 32'd0);
      add(7'h10, 0, 0, 32'd3);
      add(7'h14, 1, 32'hFFFF_FFF5, 32'd0);
      add(7'h14, 0, 0, 32'd5);
      add(7'h18, 1, 32'd2, 32'd0);
      add(7'h18, 0, 0, 32'd2);
      add(7'h60, 1, 32'h1234, 32'd0);
      add(7'h60, 0, 0, 32'd0);
      add(7'h08, 0, 0, 32'd0);
      for (int i = 0; i < vecs.size(); i++) begin
         bus(vecs[i].addr, vecs[i].w, vecs[i].d, r, v);
         chk($sformatf("reg_vec%0d_data", i), r, vecs[i].exp);
         chk($sformatf("reg_vec%0d_rs_en", i), {31'd0, v}, 32'd1);
      end
      @(negedge clk);
      chk("rs_en_drops", {31'd0, rs_en}, 32'd0);
      chk("csn_idle_csdef", 32'(spi_csn), 32'h5);

      // Mode 0, fastest SCK, single byte in AUTO mode.
      do_reset();
      wr(7'h00, 32'd0);
      wr(7'h04, 32'd0);
      exp_period = 2;
      exp_csn = 4'b1110;
      send(8'hA5);
      wait_bytes(1, 200);
      repeat (6) @(negedge clk);
      chk("auto_csn_release", 32'(spi_csn), 32'hF);
      read_rx("rx_a5");
      read_rx("rx_empty_after_a5");

      // Mode 3, half-period 3 clk.
      do_reset();
      wr(7'h00, 32'd2);
      wr(7'h04, 32'd3);
      @(negedge clk);
      chk("mode3_sck_idle_high", {31'd0, spi_clk}, 32'd1);
      exp_period = 6;
      exp_csn = 4'b1110;
      send(8'h3C);
      wait_bytes(1, 400);
      repeat (12) @(negedge clk);
      chk("mode3_csn_release", 32'(spi_csn), 32'hF);
      chk("mode3_sck_idle_after", {31'd0, spi_clk}, 32'd1);
      read_rx("rx_3c");

      // HOLD mode on CS 2 across two bytes, then release by leaving HOLD.
      do_reset();
      wr(7'h00, 32'd1);
      wr(7'h18, 32'd2);
      wr(7'h10, 32'd2);
      exp_period = 4;
      exp_csn = 4'b1011;
      send(8'h5A);
      send(8'hC3);
      wait_bytes(2, 400);
      repeat (10) @(negedge clk);
      chk("hold_csn_kept", 32'(spi_csn), 32'hB);
      wr(7'h18, 32'd0);
      chk("hold_csn_release", 32'(spi_csn), 32'hF);
      read_rx("rx_5a");
      read_rx("rx_c3");

      // TX fills to full, extra write dropped; RX overflows on the 9th byte.
      do_reset();
      wr(7'h00, 32'd100);
      exp_period = 202;
      exp_csn = 4'b1110;
      for (int i = 1; i <= 9; i++) send(8'(i * 17));
      rd_chk("tx_full_after_9", 7'h48, 32'h8000_0000);
      wr(7'h48, 32'hAA);
      rd_chk("tx_still_full", 7'h48, 32'h8000_0000);
      wait_bytes(9, 20000);
      repeat (300) @(negedge clk);
      chk("no_extra_bytes", 32'(mon_bytes), 32'd9);
      rd_chk("tx_empty_after_drain", 7'h48, 32'd0);
      for (int i = 1; i <= 9; i++) read_rx($sformatf("rx_fill%0d", i));

      // Asynchronous reset in the middle of a frame.
      do_reset();
      wr(7'h00, 32'd3);
      exp_period = 8;
      exp_csn = 4'b1110;
      wr(7'h48, 32'hF0);
      c = 0;
      while (mon_bits != 4 && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("midframe_reached_bit4", 32'(mon_bits), 32'd4);
      #2 resetn = 1'b0;
      #1;
      chk("midframe_rst_csn", 32'(spi_csn), 32'hF);
      chk("midframe_rst_sck", {31'd0, spi_clk}, 32'd0);
      chk("midframe_rst_mosi", {31'd0, spi_mosi}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      rd_chk("midframe_rx_empty", 7'h4c, 32'h8000_0000);
      rd_chk("midframe_tx_empty", 7'h48, 32'd0);
      chk("midframe_no_byte", 32'(mon_bytes), 32'd0);
`ifdef SPI_IRQ_EN
      wr(7'h50, 32'd1);
      @(negedge clk);
      chk("irq_masked", {31'd0, irq}, 32'd0);
      wr(7'h70, 32'd1);
      @(negedge clk);
      chk("irq_txwm", {31'd0, irq}, 32'd1);
      rd_chk("ip_read", 7'h74, 32'd1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
